spi_shift_reg: RTL



---
 rtl/spi_shift_reg.sv | 111 +++++++++++
 1 files changed

// File: rtl/spi_shift_reg.sv
// Purpose  : WIDTH-bit SPI data shift register with parallel load, preset, and serial
//            shift-out in either bit order. It frames exactly WIDTH bits per transfer.
// Latency  : LOAD/PRE/SHIFT take effect on the next rising CLK. SOUT is combinational from Q.
// Backpres.: LOAD is accepted only while idle. SHIFT is ignored while idle.
//            Gaps between shifts are unbounded.
// Ports    : CLK clock; CLR async active-high clear; PRE sync preset/abort;
//            LOAD/DATA parallel load; SHIFT/SIN serial shift and input bit;
//            SOUT serial out; Q contents; BIT_CNT bits shifted so far;
//            BUSY transfer active; DONE one-cycle pulse after the final shift.
module spi_shift_reg #(
    parameter int              WIDTH      = 8,
    parameter bit              MSB_FIRST  = 1'b1,
    parameter logic [WIDTH-1:0] PRESET_VAL = '0
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       PRE,
    input  logic                       LOAD,
    input  logic [WIDTH-1:0]           DATA,
    input  logic                       SHIFT,
    input  logic                       SIN,
    output logic                       SOUT,
    output logic [WIDTH-1:0]           Q,
    output logic [$clog2(WIDTH):0]     BIT_CNT,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } state_t;

    state_t           state_r, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt, q_shifted;
    logic [CW-1:0]    cnt_r, cnt_nxt;
    logic             done_r, done_nxt;

    // Bit order only decides which end leaves and which end SIN enters.
    always_comb begin
        if (MSB_FIRST) begin
            q_shifted = {q_r[WIDTH-2:0], SIN};
        end else begin
            q_shifted = {SIN, q_r[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_r <= IDLE;
            q_r     <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            q_r     <= q_nxt;
            cnt_r   <= cnt_nxt;
            done_r  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        q_nxt     = q_r;
        cnt_nxt   = cnt_r;
        done_nxt  = 1'b0;
        if (PRE) begin
            // Preset aborts any transfer silently, with no DONE pulse.
            state_nxt = IDLE;
            q_nxt     = PRESET_VAL;
            cnt_nxt   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (LOAD) begin
                        state_nxt = SHIFTING;
                        q_nxt     = DATA;
                        cnt_nxt   = '0;
                    end
                end
                SHIFTING: begin
                    // LOAD is deliberately not examined here. This includes the final shift,
                    // which forces a single idle cycle between back-to-back transfers.
                    if (SHIFT) begin
                        q_nxt = q_shifted;
                        if (cnt_r == LAST_BIT) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign Q       = q_r;
    assign BIT_CNT = cnt_r;
    assign BUSY    = (state_r == SHIFTING);
    assign DONE    = done_r;
    assign SOUT    = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];

endmodule
